tl_rx_error_check_ctrl: RTL
===========================

# tl_rx_error_check_ctrl

Sequencer for the TL RX write-handler error-check stage. It accepts one decoded TLP header at a time and presents the latched fields to the combinational unsupported-request and malformed checkers for exactly one evaluation cycle. It then issues a forward/discard decision to the write datapath and, for failing TLPs, requests an error message from the error-reporting logic. It sits between the RX header buffer and the write handler's data path.

## Interface
- `ADDRESS_WIDTH`, 64, TLP address width
- `CNT_WIDTH`, 8, width of each error counter
- `clk`  in  1  block clock
- `arst_n`  in  1  reset, asynchronous, active-low
- `hdr_valid`  in  1  header available
- `hdr_ready`  out  1  block can accept a header
- `hdr_typ`  in  3  TLP type: 000 MEM, 001 IO, 010 CPL, 011 CFG, 100 MSG
- `hdr_ep`, `hdr_rw`, `hdr_addr_typ`  in  1 each  poisoned; 1=write; 1=64-bit address
- `hdr_msg_code`  in  8  message code
- `hdr_address`  in  ADDRESS_WIDTH  request address
- `chk_ur_en`  out  1  checker enable, high only in CHECK
- `chk_typ`, `chk_ep`, `chk_rw`, `chk_addr_typ`, `chk_msg_code`, `chk_address`  out  as hdr_*  latched fields driven to the checkers
- `chk_ur_error`, `chk_mf_error`  in  1 each  checker results; valid only in CHECK
- `dec_valid`  out  1  decision valid
- `dec_ready`  in  1  datapath accepts the decision
- `dec_discard`  out  1  1 = drop the TLP
- `dec_err_code`  out  2  00 none, 01 UR, 10 MF
- `err_report_en`  in  1  error-message generation enabled
- `err_msg_req`  out  1  error message request
- `err_msg_ack`  in  1  request accepted
- `err_msg_code`  out  2  same encoding as `dec_err_code`
- `cnt_clr`  in  1  synchronous clear of the counters
- `ur_err_cnt`, `mf_err_cnt`  out  CNT_WIDTH  error counters

## Operation
The controller is a four-state FSM: IDLE, CHECK, DECIDE, REPORT. Reset forces IDLE.
- **IDLE:** `hdr_ready`=1.
  - On `hdr_valid`&`hdr_ready`, register all `hdr_*` fields into the `chk_*` registers and go to CHECK.
- **CHECK:** single cycle, with `chk_ur_en`=1.
  - Register the verdict: MF if `chk_mf_error`; else UR if `chk_ur_error`; else none. MF has priority over UR.
  - Go to DECIDE.
- **DECIDE:** `dec_valid`=1. `dec_discard` = (verdict≠none). `dec_err_code` = verdict. All three stay stable until `dec_ready`.
  - On `dec_valid`&`dec_ready` with verdict≠none and `err_report_en`=1: go to REPORT.
  - Otherwise go to IDLE.
- **REPORT:** `err_msg_req`=1 and `err_msg_code`=verdict until `err_msg_ack`, then go to IDLE.
- `err_report_en` is sampled only at the DECIDE handshake.
- Outputs are combinational decodes of the state and the registered fields. No output depends combinationally on `hdr_*`.

## Timing
- Reset values:
  - `hdr_ready`=1, since the state is IDLE.
  - `chk_ur_en`=0, `dec_valid`=0, `dec_discard`=0, `dec_err_code`=00, `err_msg_req`=0, `err_msg_code`=00.
  - All `chk_*` field registers = 0, counters = 0.
- Latency: header handshake at cycle N gives CHECK at N+1 and `dec_valid` at N+2. Best-case throughput is one TLP per 3 cycles.
- `dec_ready` held low: the FSM stays in DECIDE and the `chk_*` fields stay frozen.
- `err_msg_ack` asserted in the same cycle `err_msg_req` first rises: the FSM leaves REPORT after 1 cycle.
- `hdr_valid` is ignored outside IDLE.
- `chk_*_error` inputs are ignored outside CHECK.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and any pending decision or report is lost.
- Counters:
  - Increment at the DECIDE handshake for the corresponding verdict, independent of `err_report_en`.
  - Saturate at 2^CNT_WIDTH−1.
  - `cnt_clr` wins over a simultaneous increment; the result is 0.

## Configuration
- `UR_ERR_CNT_EN` defined: `ur_err_cnt`/`mf_err_cnt` counters and `cnt_clr` are implemented as described.
- `UR_ERR_CNT_EN` not defined: no counter flops. Both count outputs are tied to 0 and `cnt_clr` is ignored. FSM behaviour is unchanged.

## Test plan
- Clean MEM write: `hdr_typ`=000, both checker errors=0, `dec_ready`=1 → `dec_valid` at N+2, `dec_discard`=0, code 00, no `err_msg_req`, back in IDLE at N+3.
- IO request with `chk_ur_error`=1, `err_report_en`=1, `err_msg_ack` delayed 3 cycles → `dec_err_code`=01, `dec_discard`=1; `err_msg_req` held 3 cycles with code 01; `ur_err_cnt` 0→1; `hdr_ready` low throughout.
- Both `chk_mf_error` and `chk_ur_error`=1 → `dec_err_code`=10, `mf_err_cnt`+1, `ur_err_cnt` unchanged.
- `dec_ready` low for 5 cycles while `hdr_*` inputs toggle → decision outputs and `chk_*` stable; no second header accepted.
- Counter saturation with `CNT_WIDTH`=2: 5 UR TLPs → `ur_err_cnt`=3; `cnt_clr` coincident with a 6th UR → 0. Without `UR_ERR_CNT_EN` → always 0.
- `arst_n` pulsed low while in REPORT → `err_msg_req`=0 at once, `hdr_ready`=1; the next header is processed normally.

Source files
------------

// File: rtl/tl_rx_error_check_ctrl.sv
// tl_rx_error_check_ctrl
// Error-check sequencer for the TL RX write handler. It latches one decoded
// header, gives the UR/MF checkers one evaluation cycle, hands a
// forward/discard decision to the write datapath, and for failing TLPs
// requests an error message.
//
// Optional feature: define UR_ERR_CNT_EN to build the saturating UR/MF error
// counters and their synchronous clear. Without it the count outputs are
// tied to 0 and cnt_clr is ignored.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a header; fields latch on hdr_valid
// S_CHECK  | one cycle with the checkers enabled; verdict is registered
// S_DECIDE | decision presented, held until dec_ready
// S_REPORT | error message requested, held until err_msg_ack
module tl_rx_error_check_ctrl #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     hdr_valid,
  output logic                     hdr_ready,
  input  logic [2:0]               hdr_typ,
  input  logic                     hdr_ep,
  input  logic                     hdr_rw,
  input  logic                     hdr_addr_typ,
  input  logic [7:0]               hdr_msg_code,
  input  logic [ADDRESS_WIDTH-1:0] hdr_address,
  output logic                     chk_ur_en,
  output logic [2:0]               chk_typ,
  output logic                     chk_ep,
  output logic                     chk_rw,
  output logic                     chk_addr_typ,
  output logic [7:0]               chk_msg_code,
  output logic [ADDRESS_WIDTH-1:0] chk_address,
  input  logic                     chk_ur_error,
  input  logic                     chk_mf_error,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic                     dec_discard,
  output logic [1:0]               dec_err_code,
  input  logic                     err_report_en,
  output logic                     err_msg_req,
  input  logic                     err_msg_ack,
  output logic [1:0]               err_msg_code,
  input  logic                     cnt_clr,
  output logic [CNT_WIDTH-1:0]     ur_err_cnt,
  output logic [CNT_WIDTH-1:0]     mf_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_DECIDE = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_UR   = 2'b01;
  localparam logic [1:0] CODE_MF   = 2'b10;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_verdict;
  logic       w_hdr_hs;
  logic       w_dec_hs;

  assign w_hdr_hs = (r_state == S_IDLE) && hdr_valid;
  assign w_dec_hs = (r_state == S_DECIDE) && dec_ready;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and output decode; outputs depend only on state and registers
  always_comb begin
    w_next       = r_state;
    hdr_ready    = 1'b0;
    chk_ur_en    = 1'b0;
    dec_valid    = 1'b0;
    dec_discard  = 1'b0;
    dec_err_code = CODE_NONE;
    err_msg_req  = 1'b0;
    err_msg_code = CODE_NONE;
    case (r_state)
      S_IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) w_next = S_CHECK;
      end
      S_CHECK: begin
        chk_ur_en = 1'b1;
        w_next    = S_DECIDE;
      end
      S_DECIDE: begin
        dec_valid    = 1'b1;
        dec_discard  = (r_verdict != CODE_NONE);
        dec_err_code = r_verdict;
        if (dec_ready) begin
          if ((r_verdict != CODE_NONE) && err_report_en) w_next = S_REPORT;
          else                                           w_next = S_IDLE;
        end
      end
      S_REPORT: begin
        err_msg_req  = 1'b1;
        err_msg_code = r_verdict;
        if (err_msg_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Header field latch; fields stay frozen until the next accepted header
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      chk_typ      <= '0;
      chk_ep       <= 1'b0;
      chk_rw       <= 1'b0;
      chk_addr_typ <= 1'b0;
      chk_msg_code <= '0;
      chk_address  <= '0;
    end else if (w_hdr_hs) begin
      chk_typ      <= hdr_typ;
      chk_ep       <= hdr_ep;
      chk_rw       <= hdr_rw;
      chk_addr_typ <= hdr_addr_typ;
      chk_msg_code <= hdr_msg_code;
      chk_address  <= hdr_address;
    end
  end

  // Verdict capture during CHECK; malformed outranks unsupported request
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_verdict <= CODE_NONE;
    end else if (r_state == S_CHECK) begin
      if (chk_mf_error)      r_verdict <= CODE_MF;
      else if (chk_ur_error) r_verdict <= CODE_UR;
      else                   r_verdict <= CODE_NONE;
    end
  end

`ifdef UR_ERR_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] r_ur_cnt;
  logic [CNT_WIDTH-1:0] r_mf_cnt;

  // Saturating error counters, bumped at the decision handshake; clear wins
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ur_cnt <= '0;
      r_mf_cnt <= '0;
    end else if (cnt_clr) begin
      r_ur_cnt <= '0;
      r_mf_cnt <= '0;
    end else if (w_dec_hs) begin
      if ((r_verdict == CODE_UR) && (r_ur_cnt != CNT_MAX))
        r_ur_cnt <= r_ur_cnt + CNT_WIDTH'(1);
      if ((r_verdict == CODE_MF) && (r_mf_cnt != CNT_MAX))
        r_mf_cnt <= r_mf_cnt + CNT_WIDTH'(1);
    end
  end

  assign ur_err_cnt = r_ur_cnt;
  assign mf_err_cnt = r_mf_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = cnt_clr ^ w_dec_hs;
  assign ur_err_cnt   = '0;
  assign mf_err_cnt   = '0;
`endif

endmodule
